onehot_dec_seq: RTL and testbench
=================================

ONEHOT_DEC_SEQ -- requirements
Module: onehot_dec_seq

Interface
REQ-001 Parameter DIV, default 100_000_000, SHALL set rotate-step period in clk cycles (legal range 2..2^27).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous and active-high.
REQ-004 sw  input  4  SHALL carry controls: sw[1:0] code to load, sw[2] rotate enable, sw[3] output enable.
REQ-005 btn  input  1  SHALL be the asynchronous load pushbutton, active-high.
REQ-006 led  output  4  SHALL be the registered one-hot decode of the current code, or 4'b0000 when disabled.

Function
REQ-007 Block SHALL hold a 2-bit code register cur and drive led from it with mapping 0->0001, 1->0010, 2->0100, 3->1000.
REQ-008 btn SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop (s2_d); load = s2 & ~s2_d.
REQ-009 Load SHALL fire for exactly one cycle per btn rising edge, however long btn is held.
REQ-010 Latency: btn first sampled high at edge N -> cur = sw[1:0] at edge N+2 -> led updated at edge N+3.
REQ-011 sw[1:0] SHALL be sampled in the cycle load is asserted; sw[1:0] changes without load SHALL NOT affect cur.
REQ-012 Prescaler cnt (27 bits) SHALL count 0..DIV-1 while sw[2]=1 and wrap to 0; tick = (cnt == DIV-1).
REQ-013 On tick with no load, cur SHALL increment modulo 4 (3 wraps to 0); led rotates 0001->0010->0100->1000->0001.
REQ-014 While sw[2]=0, cnt SHALL be held at 0 and no tick SHALL occur; cur changes only via load.
REQ-015 Load and tick in the same cycle: load SHALL win; cur = sw[1:0], cnt SHALL reset to 0.
REQ-016 Every load SHALL reset cnt to 0 so the next rotate step occurs DIV cycles after the load edge.
REQ-017 sw[2] falling mid-count SHALL clear cnt on the next edge; rising SHALL start counting from 0.
REQ-018 sw[3]=0 SHALL force led to 4'b0000 on the next edge; cur and cnt SHALL continue to update.
REQ-019 sw[3] returning to 1 SHALL show one-hot of the then-current cur on the next edge.
REQ-020 led SHALL be one-hot or all-zero at every edge; no other pattern is legal.

Reset
REQ-021 rst=1 at an edge SHALL set cur=0, cnt=0, s1=s2=s2_d=0, led=4'b0000.
REQ-022 First edge after rst deasserts SHALL drive led = 0001 if sw[3]=1, else 0000.
REQ-023 rst SHALL override load and tick in the same cycle; a btn held through reset SHALL NOT produce a load until released and pressed again.
REQ-024 rst asserted mid-rotation SHALL abandon the partial count; rotation restarts from cnt=0, cur=0.

Verification (DIV=4)
REQ-025 Reset: rst=1 two cycles, sw=4'b1000 -> led=0000 during reset, led=0001 first edge after release.
REQ-026 Load: sw=4'b1010, btn high 10 cycles -> led=0100 exactly 3 edges after btn first sampled, one load pulse only, no further change.
REQ-027 Rotate: after reset sw=4'b1100 -> led 0001, 0010, 0100, 1000, 0001 stepping every 4 cycles.
REQ-028 Collision: rotate on, btn timed so load coincides with tick, sw[1:0]=2'b01 -> led=0010, next step to 0100 exactly 4 cycles later.
REQ-029 Enable: rotating, sw[3]=0 for 6 cycles then 1 -> led=0000 during gap, resumes at cur advanced by one step (6 cycles elapsed, 1 tick).
REQ-030 Reset mid-op: rotate on, cur=2, rst pulse 1 cycle with btn held high -> led=0001, no load until btn falls and rises again.

Source files
------------

// File: rtl/onehot_dec_seq.sv
// onehot_dec_seq: 2-bit code register shown as a registered one-hot LED
// pattern, loaded from a debounced-edge pushbutton or rotated by a prescaler.
//
// Ports:
//   clk  in   single clock, all state on rising edge
//   rst  in   synchronous active-high reset
//   sw   in   [1:0] code to load, [2] rotate enable, [3] output enable
//   btn  in   asynchronous load pushbutton, active-high
//   led  out  registered one-hot of the current code, or 0 when disabled
module onehot_dec_seq #(
    parameter int unsigned DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn,
    output logic [3:0] led
);

    localparam int unsigned CW = 27;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    // button synchronizer and edge history
    logic s1_q;
    logic s2_q;
    logic hist_q;

    // Reset-hold guard: a button held through reset must be seen low
    // at least once before it can produce a load. first_q marks the
    // single cycle after reset where s1_q still holds its reset value
    // rather than a real sample of btn.
    logic lock_q, lock_d;
    logic first_q;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cur_q, cur_d;
    logic [3:0]    led_q, led_d;

    logic load;
    logic rot_en;
    logic tick;
    logic out_en;
    logic [1:0] code;

    assign code   = sw[1:0];
    assign rot_en = sw[2];
    assign out_en = sw[3];

    assign load = s2_q & ~hist_q & ~lock_q;
    assign tick = rot_en & (cnt_q == CNT_MAX);

    // prescaler: cleared by load, by rotate disable and on wrap
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (load || !rot_en || tick) begin
            cnt_d = '0;
        end
    end

    // code register: load has priority over a rotate step
    always_comb begin
        cur_d = cur_q;
        if (load) begin
            cur_d = code;
        end else if (tick) begin
            cur_d = cur_q + 2'd1;
        end
    end

    // guard release once a genuine low button sample is seen
    always_comb begin
        lock_d = lock_q;
        if (!first_q && !s1_q) begin
            lock_d = 1'b0;
        end
    end

    // one-hot decode of the code currently held (before this edge)
    always_comb begin
        led_d = 4'b0000;
        if (out_en) begin
            unique case (cur_q)
                2'd0: led_d = 4'b0001;
                2'd1: led_d = 4'b0010;
                2'd2: led_d = 4'b0100;
                2'd3: led_d = 4'b1000;
                default: led_d = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            hist_q  <= 1'b0;
            lock_q  <= 1'b1;
            first_q <= 1'b1;
            cnt_q   <= '0;
            cur_q   <= 2'd0;
            led_q   <= 4'b0000;
        end else begin
            s1_q    <= btn;
            s2_q    <= s1_q;
            hist_q  <= s2_q;
            lock_q  <= lock_d;
            first_q <= 1'b0;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

`ifndef SYNTHESIS
    // output is always one-hot or dark
    a_led_legal: assert property (@(posedge clk) $onehot0(led_q));
    // the prescaler never runs past its terminal count
    a_cnt_range: assert property (@(posedge clk) cnt_q <= CNT_MAX);
    // a load lasts exactly one cycle
    a_load_pulse: assert property (@(posedge clk) disable iff (rst)
        load |=> !load);
`endif

endmodule

// File: tb/tb_onehot_dec_seq.sv
// tb_onehot_dec_seq: directed stimulus with a cycle-stamped scoreboard of
// hand-computed LED values, checked by an independent negedge monitor.
module tb_onehot_dec_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic [3:0] sw;
    logic [3:0] led;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];

    onehot_dec_seq #(.DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .btn (btn),
        .led (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // expect led == v after k more rising edges
    task automatic expect_at(input int k, input logic [3:0] v,
                             input string nm);
        exp_t e;
        e.cyc  = cyc + k;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor
    always @(negedge clk) begin
        exp_t e;
        n_chk++;
        if (!$onehot0(led)) begin
            n_fail++;
            $display("FAIL legal cyc=%0d led=%b required onehot0",
                     cyc, led);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s missed slot cyc=%0d now=%0d",
                         e.name, e.cyc, cyc);
            end else if (led !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc=%0d led=%b required %b",
                         e.name, cyc, led, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        sw  = 4'b1000;
        btn = 1'b0;

        // reset and release
        step(1);
        expect_at(0, 4'b0000, "rst_e1");
        step(1);
        expect_at(0, 4'b0000, "rst_e2");
        rst = 1'b0;
        expect_at(1, 4'b0001, "rst_rel");
        step(2);

        // load code 2 with long press; code change mid-press ignored
        sw  = 4'b1010;
        btn = 1'b1;
        expect_at(1, 4'b0001, "ld_lat1");
        expect_at(2, 4'b0001, "ld_lat2");
        expect_at(3, 4'b0001, "ld_lat3");
        expect_at(4, 4'b0100, "ld_hit");
        step(4);
        sw = 4'b1011;
        expect_at(4, 4'b0100, "ld_once1");
        expect_at(8, 4'b0100, "ld_once2");
        step(6);
        btn = 1'b0;
        step(4);

        // rotate from reset
        rst = 1'b1;
        sw  = 4'b1100;
        expect_at(1, 4'b0000, "rot_rst");
        step(1);
        rst = 1'b0;
        expect_at(1, 4'b0001, "rot_s0a");
        expect_at(4, 4'b0001, "rot_s0b");
        expect_at(5, 4'b0010, "rot_s1a");
        expect_at(8, 4'b0010, "rot_s1b");
        expect_at(9, 4'b0100, "rot_s2");
        expect_at(13, 4'b1000, "rot_s3a");
        expect_at(16, 4'b1000, "rot_s3b");
        expect_at(17, 4'b0001, "rot_wrap");
        expect_at(21, 4'b0010, "rot_s1c");
        step(21);

        // load of code 1 landing on the same edge as a tick
        sw  = 4'b1101;
        btn = 1'b1;
        expect_at(3, 4'b0010, "col_pre");
        expect_at(4, 4'b0010, "col_hit");
        expect_at(7, 4'b0010, "col_hold");
        expect_at(8, 4'b0100, "col_next");
        step(3);
        btn = 1'b0;
        step(6);

        // load off-tick restarts the prescaler
        sw  = 4'b1100;
        btn = 1'b1;
        expect_at(1, 4'b0100, "rs_pre");
        expect_at(3, 4'b1000, "rs_tick");
        expect_at(4, 4'b0001, "rs_load");
        expect_at(7, 4'b0001, "rs_hold");
        expect_at(8, 4'b0010, "rs_step");
        step(3);
        btn = 1'b0;
        step(5);

        // output disable gap of 6 cycles
        sw = 4'b0100;
        expect_at(1, 4'b0000, "en_off1");
        expect_at(3, 4'b0000, "en_off3");
        expect_at(6, 4'b0000, "en_off6");
        step(6);
        sw = 4'b1100;
        expect_at(1, 4'b0100, "en_back");
        expect_at(2, 4'b1000, "en_next");
        step(3);

        // reset mid-rotation with button held through it
        step(11);
        expect_at(0, 4'b0100, "mr_cur2");
        rst = 1'b1;
        btn = 1'b1;
        sw  = 4'b1011;
        expect_at(1, 4'b0000, "mr_rst");
        step(1);
        rst = 1'b0;
        expect_at(1, 4'b0001, "mr_rel");
        expect_at(4, 4'b0001, "mr_noload1");
        expect_at(8, 4'b0001, "mr_noload2");
        step(6);
        btn = 1'b0;
        step(4);
        btn = 1'b1;
        expect_at(3, 4'b0001, "mr_repress_pre");
        expect_at(4, 4'b1000, "mr_repress");
        step(6);
        btn = 1'b0;
        step(4);

        for (int i = 0; i < 50 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s never checked cyc=%0d", e.name, e.cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
